// File: rtl/stream_ser_pkg.sv
// Shared types and helpers for the stream serializer.
//   state_e   : serializer control states (IDLE, SHIFT)
//   clamp_len : maps a requested element count onto the last element index
package stream_ser_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Counts of 0 or above the vector capacity mean "whole vector".
    // The result is the last index (count - 1); callers narrow it to their
    // counter width, which always holds features - 1.
    function automatic int unsigned clamp_len(input int unsigned num_elems,
                                              input int unsigned features);
        if ((num_elems == 0) || (num_elems > features)) begin
            return features - 1;
        end
        return num_elems - 1;
    endfunction

endpackage

// File: rtl/stream_serializer.sv
// Parallel-to-serial converter with valid/ready handshakes on both sides.
// Captures a FEATURES x ELEMENT_BITS vector and emits 1..FEATURES elements,
// lowest element first (MSB_FIRST=0) or highest requested element first
// (MSB_FIRST=1). A new vector may be accepted on the same cycle as the final
// element handshake, so back-to-back vectors stream without a bubble.
//
// Ports:
//   clk              : clock, rising edge
//   reset_n          : synchronous active-low reset
//   in_valid         : parallel_data_in / num_elems are valid
//   in_ready         : a vector can be accepted this cycle
//   parallel_data_in : element i at [i*ELEMENT_BITS +: ELEMENT_BITS]
//   num_elems        : elements to emit (0 or >FEATURES means FEATURES)
//   out_valid        : serial_data_out holds a valid element
//   out_ready        : downstream accepts the element
//   serial_data_out  : current element (0 while idle)
//   out_last         : current element is the final one of its vector
//   busy             : a vector is held
//   done             : one-cycle pulse after the final element handshake
module stream_serializer
    import stream_ser_pkg::*;
#(
    parameter int unsigned ELEMENT_BITS = 8,
    parameter int unsigned FEATURES     = 4,
    parameter bit          MSB_FIRST    = 1'b0,
    parameter int unsigned CNT_BITS     = $clog2(FEATURES)
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [FEATURES*ELEMENT_BITS-1:0] parallel_data_in,
    input  logic [CNT_BITS:0]                num_elems,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ELEMENT_BITS-1:0]          serial_data_out,
    output logic                             out_last,
    output logic                             busy,
    output logic                             done
);

    localparam int unsigned VEC_BITS = FEATURES * ELEMENT_BITS;

    state_e                  state_q, state_d;
    logic [VEC_BITS-1:0]     hold_q, hold_d;
    logic [CNT_BITS-1:0]     len_q, len_d;
    logic [CNT_BITS-1:0]     idx_q, idx_d;
    logic                    done_q, done_d;

    logic [CNT_BITS-1:0]     cap_len;
    logic [CNT_BITS-1:0]     term_idx;
    logic [ELEMENT_BITS-1:0] elem;
    logic                    out_fire;
    logic                    in_fire;

    // Last index of the incoming vector, clamped once at capture.
    assign cap_len  = CNT_BITS'(clamp_len(32'(num_elems), FEATURES));

    // Index of the element that closes the vector.
    assign term_idx = MSB_FIRST ? '0 : len_q;

    // Element select from the holding register.
    always_comb begin
        elem = '0;
        for (int i = 0; i < int'(FEATURES); i++) begin
            if (idx_q == CNT_BITS'(i)) begin
                elem = hold_q[i*ELEMENT_BITS +: ELEMENT_BITS];
            end
        end
    end

    // Outputs depend only on registers and out_ready.
    assign out_valid       = (state_q == SHIFT);
    assign busy            = out_valid;
    assign out_last        = out_valid && (idx_q == term_idx);
    assign serial_data_out = out_valid ? elem : '0;
    assign out_fire        = out_valid && out_ready;
    assign in_ready        = (state_q == IDLE) || (out_fire && out_last);
    assign in_fire         = in_valid && in_ready;
    assign done            = done_q;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        len_d   = len_q;
        idx_d   = idx_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // Capture handled below.
            end
            SHIFT: begin
                if (out_fire) begin
                    if (out_last) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (MSB_FIRST) begin
                        idx_d = idx_q - CNT_BITS'(1);
                    end else begin
                        idx_d = idx_q + CNT_BITS'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Acceptance in IDLE or on the final handshake; the latter keeps
        // SHIFT so the next vector follows without a gap.
        if (in_fire) begin
            hold_d  = parallel_data_in;
            len_d   = cap_len;
            idx_d   = MSB_FIRST ? cap_len : '0;
            state_d = SHIFT;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_stream_serializer.sv
// Bench for stream_serializer: two instances (LSB-first and MSB-first) share
// all inputs and are compared every cycle against a queue-based model of the
// expected element stream.
module tb_stream_serializer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] pdata;
    logic [2:0]  num_elems;

    logic        in_ready0, out_valid0, out_last0, busy0, done0;
    logic [7:0]  sdo0;
    logic        in_ready1, out_valid1, out_last1, busy1, done1;
    logic [7:0]  sdo1;

    always #5 clk = ~clk;

    stream_serializer #(.ELEMENT_BITS(8), .FEATURES(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready0),
        .parallel_data_in(pdata), .num_elems(num_elems), .out_valid(out_valid0),
        .out_ready(out_ready), .serial_data_out(sdo0), .out_last(out_last0),
        .busy(busy0), .done(done0)
    );

    stream_serializer #(.ELEMENT_BITS(8), .FEATURES(4), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
        .parallel_data_in(pdata), .num_elems(num_elems), .out_valid(out_valid1),
        .out_ready(out_ready), .serial_data_out(sdo1), .out_last(out_last1),
        .busy(busy1), .done(done1)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       last;
    } elem_t;

    elem_t q0[$];
    elem_t q1[$];
    logic  done_exp0, done_exp1;
    logic  acc;
    int    tests, fails;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // Expected element stream of one accepted vector for each emission order.
    task automatic push_vec(input logic [31:0] v, input logic [2:0] n_raw);
        int n;
        n = ((n_raw == 3'd0) || (n_raw > 3'd4)) ? 4 : int'(n_raw);
        for (int k = 0; k < n; k++) q0.push_back('{d: v[k*8 +: 8], last: (k == n - 1)});
        for (int k = n - 1; k >= 0; k--) q1.push_back('{d: v[k*8 +: 8], last: (k == 0)});
    endtask

    // Check current outputs, then advance the model across one rising edge.
    task automatic tick();
        elem_t h0, h1;
        logic  ne0, ne1, er0, er1;
        #1;
        ne0 = (q0.size() != 0);
        ne1 = (q1.size() != 0);
        h0  = ne0 ? q0[0] : '0;
        h1  = ne1 ? q1[0] : '0;
        er0 = !ne0 || (out_ready && h0.last);
        er1 = !ne1 || (out_ready && h1.last);
        chk("lsb_out_valid", 32'(out_valid0), 32'(ne0));
        chk("lsb_data",      32'(sdo0),       32'(h0.d));
        chk("lsb_out_last",  32'(out_last0),  32'(h0.last));
        chk("lsb_in_ready",  32'(in_ready0),  32'(er0));
        chk("lsb_busy",      32'(busy0),      32'(ne0));
        chk("lsb_done",      32'(done0),      32'(done_exp0));
        chk("msb_out_valid", 32'(out_valid1), 32'(ne1));
        chk("msb_data",      32'(sdo1),       32'(h1.d));
        chk("msb_out_last",  32'(out_last1),  32'(h1.last));
        chk("msb_in_ready",  32'(in_ready1),  32'(er1));
        chk("msb_busy",      32'(busy1),      32'(ne1));
        chk("msb_done",      32'(done1),      32'(done_exp1));
        acc = reset_n && in_valid && er0;
        @(posedge clk);
        if (!reset_n) begin
            q0.delete();
            q1.delete();
            done_exp0 = 1'b0;
            done_exp1 = 1'b0;
        end else begin
            done_exp0 = ne0 && out_ready && h0.last;
            done_exp1 = ne1 && out_ready && h1.last;
            if (ne0 && out_ready) void'(q0.pop_front());
            if (ne1 && out_ready) void'(q1.pop_front());
            if (acc) push_vec(pdata, num_elems);
        end
        @(negedge clk);
    endtask

    // Present a vector and hold in_valid until the model says it was taken.
    task automatic send(input logic [31:0] v, input logic [2:0] n);
        int guard;
        guard     = 0;
        pdata     = v;
        num_elems = n;
        in_valid  = 1'b1;
        do begin
            tick();
            guard++;
        end while (!acc && guard < 40);
        tests++;
        assert (acc) else begin
            fails++;
            $error("FAIL send_accept observed=%0d expected=1", acc);
        end
    endtask

    logic bp [6];

    initial begin
        tests     = 0;
        fails     = 0;
        done_exp0 = 1'b0;
        done_exp1 = 1'b0;
        acc       = 1'b0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        pdata     = '0;
        num_elems = '0;
        bp        = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Full vector, continuous out_ready.
        send(32'h44332211, 3'd4);
        in_valid = 1'b0;
        repeat (6) tick();

        // Partial vector.
        send(32'h44332211, 3'd3);
        in_valid = 1'b0;
        repeat (5) tick();

        // Back-pressure with the next vector waiting.
        send(32'h44332211, 3'd4);
        pdata     = 32'hDDCCBBAA;
        num_elems = 3'd4;
        foreach (bp[i]) begin
            out_ready = bp[i];
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();

        // Back-to-back vectors.
        send(32'h44332211, 3'd4);
        send(32'hDDCCBBAA, 3'd4);
        in_valid = 1'b0;
        repeat (6) tick();

        // Count clamping and single element.
        send(32'h44332211, 3'd0);
        in_valid = 1'b0;
        repeat (6) tick();
        send(32'h44332211, 3'd7);
        in_valid = 1'b0;
        repeat (6) tick();
        send(32'h44332211, 3'd1);
        in_valid = 1'b0;
        repeat (3) tick();

        // Reset after the second element, then a fresh vector.
        send(32'h44332211, 3'd4);
        in_valid = 1'b0;
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        send(32'hDDCCBBAA, 3'd4);
        in_valid = 1'b0;
        repeat (6) tick();

        // Random traffic, back-pressure and occasional reset.
        for (int i = 0; i < 1500; i++) begin
            if (!in_valid || acc) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                pdata     = $urandom;
                num_elems = 3'($urandom_range(0, 7));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            reset_n   = ($urandom_range(0, 63) != 0);
            tick();
        end
        reset_n   = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (12) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
